// File: rtl/hbridge_deadtime_pkg.sv
// hbridge_deadtime_pkg
//   Shared constants for the H-bridge dead-time stage: the per-leg state
//   encoding, the decoded request type, the leg index constants
//   (0=A1, 1=A2, 2=B1, 3=B2) and the small helpers used by the leg FSM.
package hbridge_deadtime_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_DEAD = 2'd3
  } leg_state_e;

  // A BOTH request (hi and lo together) decodes to REQ_NONE.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_HI   = 2'd1,
    REQ_LO   = 2'd2
  } leg_req_e;

  localparam int unsigned LEG_A1 = 0;
  localparam int unsigned LEG_A2 = 1;
  localparam int unsigned LEG_B1 = 2;
  localparam int unsigned LEG_B2 = 3;

  function automatic leg_req_e decode_req(input logic hi, input logic lo);
    leg_req_e r;
    r = REQ_NONE;
    if (hi && !lo) r = REQ_HI;
    else if (lo && !hi) r = REQ_LO;
    return r;
  endfunction

  // Leg state that satisfies a request once the dead interval has expired.
  function automatic leg_state_e req_state(input leg_req_e r);
    leg_state_e s;
    s = S_OFF;
    if (r == REQ_HI) s = S_HI;
    else if (r == REQ_LO) s = S_LO;
    return s;
  endfunction

endpackage

// File: rtl/hbridge_leg.sv
// hbridge_leg
//   One half-bridge leg: OFF/HI/LO/DEAD state machine, 8-bit dead-interval
//   counter and registered gate outputs. The two switches are never on
//   together; every transition between them passes through DEAD for
//   dead_cycles+1 cycles.
// Ports:
//   CLK, resetn     clock, synchronous active-low reset
//   gate_en         drive permission (enable, qualified by the fault latch)
//   dead_cycles     dead-interval count, loaded on entry to DEAD
//   hi_req, lo_req  requested high/low-side drive
//   hi_out, lo_out  registered gate drives
//   dead_active     leg is in DEAD
module hbridge_leg
  import hbridge_deadtime_pkg::*;
#(
  parameter logic [7:0] DEAD_RESET = 8'd16
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       gate_en,
  input  logic [7:0] dead_cycles,
  input  logic       hi_req,
  input  logic       lo_req,
  output logic       hi_out,
  output logic       lo_out,
  output logic       dead_active
);

  leg_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hi_out_q, hi_out_d;
  logic       lo_out_q, lo_out_d;
  logic       dead_q, dead_d;
  leg_req_e   req;

  always_comb begin
    req     = decode_req(hi_req, lo_req);
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!gate_en) begin
      // Held in DEAD with a fresh count so re-enable always waits the full interval.
      state_d = S_DEAD;
      cnt_d   = dead_cycles;
    end else begin
      case (state_q)
        S_OFF: state_d = req_state(req);
        S_HI: begin
          if (req != REQ_HI) begin
            state_d = S_DEAD;
            cnt_d   = dead_cycles;
          end
        end
        S_LO: begin
          if (req != REQ_LO) begin
            state_d = S_DEAD;
            cnt_d   = dead_cycles;
          end
        end
        S_DEAD: begin
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          else state_d = req_state(req);
        end
      endcase
    end
    // Outputs follow the next state so they are flops aligned with the state edge.
    hi_out_d = (state_d == S_HI);
    lo_out_d = (state_d == S_LO);
    dead_d   = (state_d == S_DEAD);
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q  <= S_DEAD;
      cnt_q    <= DEAD_RESET;
      hi_out_q <= 1'b0;
      lo_out_q <= 1'b0;
      dead_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_out_q <= hi_out_d;
      lo_out_q <= lo_out_d;
      dead_q   <= dead_d;
    end
  end

  assign hi_out      = hi_out_q;
  assign lo_out      = lo_out_q;
  assign dead_active = dead_q;

endmodule

// File: rtl/hbridge_deadtime.sv
// hbridge_deadtime
//   Shoot-through protection between the phase logic and the H-bridge gate
//   pins. Instantiates one hbridge_leg per half-bridge leg (0=A1, 1=A2,
//   2=B1, 3=B2) and applies the global enable / fault gating.
//   Optional feature macro: HBRIDGE_FAULT_EN adds a sticky fault latch set by
//   a hi+lo (BOTH) request while enabled; while set, all legs act disabled.
// Ports:
//   CLK, resetn     clock, synchronous active-low reset
//   enable          global drive enable, low forces all gates off
//   dead_cycles     runtime dead-interval count
//   hi_req, lo_req  per-leg requested drive
//   hi_out, lo_out  per-leg registered gate drives
//   dead_active     per-leg DEAD indicator
//   fault           sticky fault (HBRIDGE_FAULT_EN only)
//   fault_clr       fault clear strobe (HBRIDGE_FAULT_EN only)
module hbridge_deadtime
  import hbridge_deadtime_pkg::*;
#(
  parameter logic [7:0]  DEAD_RESET = 8'd16,
  parameter int unsigned LEGS       = 4
) (
  input  logic            CLK,
  input  logic            resetn,
  input  logic            enable,
  input  logic [7:0]      dead_cycles,
  input  logic [LEGS-1:0] hi_req,
  input  logic [LEGS-1:0] lo_req,
  output logic [LEGS-1:0] hi_out,
  output logic [LEGS-1:0] lo_out,
  output logic [LEGS-1:0] dead_active
`ifdef HBRIDGE_FAULT_EN
  ,
  output logic            fault,
  input  logic            fault_clr
`endif
);

  logic gate_en;

`ifdef HBRIDGE_FAULT_EN
  logic fault_q, fault_d;
  logic any_both;

  always_comb begin
    any_both = |(hi_req & lo_req);
    if (fault_q) fault_d = !(fault_clr && !any_both);
    else         fault_d = enable && any_both;
    // Gate on the next fault value so the offending edge already shuts every leg.
    gate_en = enable && !fault_d;
  end

  always_ff @(posedge CLK) begin
    if (!resetn) fault_q <= 1'b0;
    else         fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  always_comb gate_en = enable;
`endif

  for (genvar g = 0; g < LEGS; g++) begin : g_leg
    hbridge_leg #(
      .DEAD_RESET(DEAD_RESET)
    ) u_leg (
      .CLK        (CLK),
      .resetn     (resetn),
      .gate_en    (gate_en),
      .dead_cycles(dead_cycles),
      .hi_req     (hi_req[g]),
      .lo_req     (lo_req[g]),
      .hi_out     (hi_out[g]),
      .lo_out     (lo_out[g]),
      .dead_active(dead_active[g])
    );
  end

endmodule

// File: tb/tb_hbridge_deadtime.sv
// tb_hbridge_deadtime
//   Directed scenarios plus randomized stimulus for hbridge_deadtime, checked
//   every cycle against a behavioural model that tracks, per leg, the driven
//   side and the remaining both-off time. Define HBRIDGE_FAULT_EN to include
//   the fault-latch scenario.
module tb_hbridge_deadtime;

  localparam int LEGS = 4;

  logic            CLK = 1'b0;
  logic            resetn;
  logic            enable;
  logic [7:0]      dead_cycles;
  logic [LEGS-1:0] hi_req, lo_req;
  logic [LEGS-1:0] hi_out, lo_out, dead_active;
`ifdef HBRIDGE_FAULT_EN
  logic            fault;
  logic            fault_clr;
`endif

  always #5 CLK = ~CLK;

  hbridge_deadtime #(
    .DEAD_RESET(8'd16),
    .LEGS      (LEGS)
  ) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .enable     (enable),
    .dead_cycles(dead_cycles),
    .hi_req     (hi_req),
    .lo_req     (lo_req),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .dead_active(dead_active)
`ifdef HBRIDGE_FAULT_EN
    ,
    .fault      (fault),
    .fault_clr  (fault_clr)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: side[i] is 0 none, 1 high, 2 low; off_left[i] is the number of
  // further edges the leg must stay fully off (-1 when not in a dead interval).
  int side[LEGS];
  int off_left[LEGS];
  bit m_fault = 0;

  task automatic model_edge();
    bit gate;
    int r;
    if (!resetn) begin
      for (int i = 0; i < LEGS; i++) begin
        side[i] = 0;
        off_left[i] = 16;
      end
      m_fault = 0;
      return;
    end
    gate = enable;
`ifdef HBRIDGE_FAULT_EN
    if (m_fault) m_fault = !(fault_clr && ((hi_req & lo_req) == 0));
    else         m_fault = enable && ((hi_req & lo_req) != 0);
    gate = enable && !m_fault;
`endif
    for (int i = 0; i < LEGS; i++) begin
      r = (hi_req[i] && !lo_req[i]) ? 1 : (lo_req[i] && !hi_req[i]) ? 2 : 0;
      if (!gate) begin
        side[i] = 0;
        off_left[i] = int'(dead_cycles);
      end else if (off_left[i] > 0) begin
        off_left[i]--;
      end else if (off_left[i] == 0) begin
        off_left[i] = -1;
        side[i] = r;
      end else if (side[i] == 0) begin
        side[i] = r;
      end else if (r != side[i]) begin
        side[i] = 0;
        off_left[i] = int'(dead_cycles);
      end
    end
  endtask

  task automatic step();
    logic [LEGS-1:0] e_hi, e_lo, e_dead;
    @(posedge CLK);
    model_edge();
    #1;
    for (int i = 0; i < LEGS; i++) begin
      e_hi[i]   = (off_left[i] < 0) && (side[i] == 1);
      e_lo[i]   = (off_left[i] < 0) && (side[i] == 2);
      e_dead[i] = (off_left[i] >= 0);
    end
    check("hi_out", int'(hi_out), int'(e_hi));
    check("lo_out", int'(lo_out), int'(e_lo));
    check("dead_active", int'(dead_active), int'(e_dead));
    check("shoot_through", int'(hi_out & lo_out), 0);
`ifdef HBRIDGE_FAULT_EN
    check("fault", int'(fault), int'(m_fault));
`endif
  endtask

  // Steps until the selected output of a leg is 1; n is the edge count
  // (the first edge counted as 1) or -1 if the budget runs out.
  task automatic wait_rise(input int leg, input bit want_hi, input int maxc, output int n);
    n = -1;
    for (int k = 1; k <= maxc; k++) begin
      step();
      if (want_hi ? hi_out[leg] : lo_out[leg]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    resetn      = 1'b0;
    enable      = 1'b1;
    dead_cycles = 8'd16;
    hi_req      = '0;
    lo_req      = '0;
`ifdef HBRIDGE_FAULT_EN
    fault_clr   = 1'b0;
`endif

    // Reset, then leg 0 requests HI from release: rises on the 17th edge.
    step();
    step();
    hi_req = 4'b0001;
    resetn = 1'b1;
    wait_rise(0, 1'b1, 40, n);
    check("reset_to_hi_edges", n, 17);
    check("reset_other_outputs", int'({hi_out[3:1], lo_out}), 0);

    // dead_cycles=5: leg 1 HI -> LO.
    dead_cycles = 8'd5;
    hi_req = 4'b0011;
    for (int i = 0; i < 4; i++) step();
    check("leg1_hi", int'(hi_out[1]), 1);
    hi_req = 4'b0001;
    lo_req = 4'b0010;
    wait_rise(1, 1'b0, 20, n);
    check("leg1_hi_to_lo_edges", n, 7);

    // dead_cycles=0: leg 2 toggles HI/LO every cycle.
    dead_cycles = 8'd0;
    for (int i = 0; i < 16; i++) begin
      hi_req[2] = (i % 2 == 0);
      lo_req[2] = (i % 2 == 1);
      step();
    end
    hi_req[2] = 1'b0;
    lo_req[2] = 1'b0;
    step();

    // Leg 3 LO, enable low for 3 cycles with dead_cycles=4.
    dead_cycles = 8'd4;
    lo_req[3] = 1'b1;
    step();
    step();
    check("leg3_lo", int'(lo_out[3]), 1);
    enable = 1'b0;
    step();
    check("leg3_off_on_disable", int'(lo_out[3]), 0);
    step();
    step();
    enable = 1'b1;
    wait_rise(3, 1'b0, 20, n);
    check("leg3_reenable_edges", n, 5);

    // Mid-count dead_cycles change on leg 0 (HI -> LO).
    check("leg0_hi_before_midcount", int'(hi_out[0]), 1);
    dead_cycles = 8'd10;
    hi_req[0] = 1'b0;
    lo_req[0] = 1'b1;
    step();
    step();
    dead_cycles = 8'd2;
    wait_rise(0, 1'b0, 30, n);
    check("leg0_midcount_edges", n, 10);

`ifdef HBRIDGE_FAULT_EN
    // BOTH on leg 0 sets fault and shuts all legs; clear only once BOTH is gone.
    dead_cycles = 8'd3;
    hi_req[0] = 1'b1;
    step();
    check("fault_set", int'(fault), 1);
    check("fault_all_off", int'(hi_out | lo_out), 0);
    fault_clr = 1'b1;
    step();
    check("fault_clr_blocked", int'(fault), 1);
    hi_req[0] = 1'b0;
    step();
    check("fault_cleared", int'(fault), 0);
    fault_clr = 1'b0;
    wait_rise(0, 1'b0, 20, n);
    check("fault_recover_edges", n, 3);
`endif

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, LEGS - 1);
        n = $urandom_range(0, 3);
`ifndef HBRIDGE_FAULT_EN
        hi_req[r] = n[0];
        lo_req[r] = n[1];
`else
        // Keep BOTH requests rare so the fault latch does not dominate.
        if (n == 3 && $urandom_range(0, 5) != 0) n = 1;
        hi_req[r] = n[0];
        lo_req[r] = n[1];
        fault_clr = ($urandom_range(0, 5) == 0);
`endif
      end
      if ($urandom_range(0, 19) == 0) dead_cycles = 8'($urandom_range(0, 6));
      enable = ($urandom_range(0, 24) != 0);
      resetn = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
